prbs_bit_gen: RTL and testbench

Programmable PRBS bit source that sits directly upstream of the PRBS edge shaper in the DAC datapath. It generates the pattern bit `prbs_bit_out` and the one-cycle bit-strobe `lfsr_clk_enable` at a rate set by a 32-bit phase-accumulator tuning word. It supports PRBS7/9/15/23/31 with a loadable seed, single-bit error injection and a sequence-wrap marker. All logic runs on `dac_clk` (625 MHz).

---
 rtl/prbs_pkg.sv | 57 +++++
 rtl/prbs_rate_nco.sv | 48 ++++
 rtl/prbs_bit_gen.sv | 129 ++++++++++++
 tb/tb_prbs_bit_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared PRBS order codes, LFSR length/tap constants, order mask
//            and FSM encoding for the PRBS bit source and edge shaper.
// Revision : 1.0  initial release
// ============================================================================
package prbs_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int LFSR_W_DEF = 31;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_order_e;

    localparam int PRBS7_LEN  = 7;
    localparam int PRBS7_TAP  = 6;
    localparam int PRBS9_LEN  = 9;
    localparam int PRBS9_TAP  = 5;
    localparam int PRBS15_LEN = 15;
    localparam int PRBS15_TAP = 14;
    localparam int PRBS23_LEN = 23;
    localparam int PRBS23_TAP = 18;
    localparam int PRBS31_LEN = 31;
    localparam int PRBS31_TAP = 28;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Unused select codes fall back to the shortest sequence.
    function automatic prbs_order_e decode_order(input logic [2:0] sel);
        case (sel)
            3'd1:    return PRBS9;
            3'd2:    return PRBS15;
            3'd3:    return PRBS23;
            3'd4:    return PRBS31;
            default: return PRBS7;
        endcase
    endfunction

    function automatic logic [LFSR_W_DEF-1:0] order_mask(input prbs_order_e ord);
        case (ord)
            PRBS9:   return 31'h0000_01FF;
            PRBS15:  return 31'h0000_7FFF;
            PRBS23:  return 31'h007F_FFFF;
            PRBS31:  return 31'h7FFF_FFFF;
            default: return 31'h0000_007F;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_rate_nco.sv
`default_nettype none
// ============================================================================
// Module   : prbs_rate_nco
// Purpose  : Phase accumulator; tick is the carry out of acc + ftw.
// Revision : 1.0  initial release
// ============================================================================
module prbs_rate_nco
    import prbs_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             dac_clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [ACC_W-1:0] ftw_i,
    output logic             tick_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;
    logic             adv;

    assign adv = run_i & ~clr_i;
    assign sum = {1'b0, acc_q} + {1'b0, ftw_i};

    // Outside RUN (or on clear) the accumulator sits at zero so a restart
    // always begins from a known phase.
    always_comb begin
        acc_d = '0;
        if (adv) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    assign tick_o = adv & sum[ACC_W];

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_bit_gen.sv
`default_nettype none
// ============================================================================
// Module   : prbs_bit_gen
// Purpose  : Programmable-rate PRBS7/9/15/23/31 bit source with seed load,
//            single-bit error injection and sequence-wrap marker.
// Revision : 1.0  initial release
// ============================================================================
module prbs_bit_gen
    import prbs_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LFSR_W = LFSR_W_DEF
) (
    input  logic              dac_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        prbs_order_sel,
    input  logic [ACC_W-1:0]  bit_rate_ftw,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_load,
    input  logic              error_inject,
    output logic              prbs_bit_out,
    output logic              lfsr_clk_enable,
    output logic              seq_wrap,
    output logic [LFSR_W-1:0] lfsr_state_dbg,
    output logic              gen_state_dbg
);

    logic [0:0]        state_q, state_d;
    prbs_order_e       order_q, order_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] wrap_ref_q, wrap_ref_d;
    logic              inject_q, inject_d;
    logic              bit_q, bit_d;
    logic              strobe_q, strobe_d;
    logic              wrap_q, wrap_d;

    logic              tick;
    logic              fb;
    logic              inj_now;
    prbs_order_e       load_order;
    logic [LFSR_W-1:0] cur_mask;
    logic [LFSR_W-1:0] load_mask;
    logic [LFSR_W-1:0] seed_masked;
    logic [LFSR_W-1:0] load_val;
    logic [LFSR_W-1:0] shifted;

    prbs_rate_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .dac_clk (dac_clk),
        .reset   (reset),
        .run_i   (state_q == ST_RUN),
        .clr_i   (seed_load),
        .ftw_i   (bit_rate_ftw),
        .tick_o  (tick)
    );

    always_comb begin
        case (order_q)
            PRBS9:   fb = lfsr_q[PRBS9_LEN-1]  ^ lfsr_q[PRBS9_TAP-1];
            PRBS15:  fb = lfsr_q[PRBS15_LEN-1] ^ lfsr_q[PRBS15_TAP-1];
            PRBS23:  fb = lfsr_q[PRBS23_LEN-1] ^ lfsr_q[PRBS23_TAP-1];
            PRBS31:  fb = lfsr_q[PRBS31_LEN-1] ^ lfsr_q[PRBS31_TAP-1];
            default: fb = lfsr_q[PRBS7_LEN-1]  ^ lfsr_q[PRBS7_TAP-1];
        endcase
    end

    assign cur_mask    = LFSR_W'(order_mask(order_q));
    assign shifted     = {lfsr_q[LFSR_W-2:0], fb} & cur_mask;
    assign load_order  = decode_order(prbs_order_sel);
    assign load_mask   = LFSR_W'(order_mask(load_order));
    assign seed_masked = seed & load_mask;
    // An all-zero seed would lock the LFSR; substitute all-ones.
    assign load_val    = (seed_masked == '0) ? load_mask : seed_masked;
    assign inj_now     = inject_q | error_inject;

    always_comb begin
        state_d    = enable ? ST_RUN : ST_IDLE;
        order_d    = order_q;
        lfsr_d     = lfsr_q;
        wrap_ref_d = wrap_ref_q;
        inject_d   = inj_now;
        bit_d      = bit_q;
        strobe_d   = 1'b0;
        wrap_d     = 1'b0;
        if (seed_load) begin
            order_d    = load_order;
            lfsr_d     = load_val;
            wrap_ref_d = load_val;
        end else if (tick) begin
            lfsr_d   = shifted;
            bit_d    = fb ^ inj_now;
            strobe_d = 1'b1;
            wrap_d   = (shifted == wrap_ref_q);
            inject_d = 1'b0;
        end
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            order_q    <= PRBS7;
            lfsr_q     <= LFSR_W'(order_mask(PRBS7));
            wrap_ref_q <= LFSR_W'(order_mask(PRBS7));
            inject_q   <= 1'b0;
            bit_q      <= 1'b0;
            strobe_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            order_q    <= order_d;
            lfsr_q     <= lfsr_d;
            wrap_ref_q <= wrap_ref_d;
            inject_q   <= inject_d;
            bit_q      <= bit_d;
            strobe_q   <= strobe_d;
            wrap_q     <= wrap_d;
        end
    end

    assign prbs_bit_out    = bit_q;
    assign lfsr_clk_enable = strobe_q;
    assign seq_wrap        = wrap_q;
    assign lfsr_state_dbg  = lfsr_q;
    assign gen_state_dbg   = state_q[0];

endmodule
`default_nettype wire

// File: tb/tb_prbs_bit_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_bit_gen
// Purpose  : Self-checking bench for prbs_bit_gen against a bit-history model.
// Revision : 1.0  initial release
// ============================================================================
module tb_prbs_bit_gen;

    logic        dac_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  prbs_order_sel = 3'd0;
    logic [31:0] bit_rate_ftw = 32'd0;
    logic [30:0] seed = 31'd0;
    logic        seed_load = 1'b0;
    logic        error_inject = 1'b0;
    logic        prbs_bit_out;
    logic        lfsr_clk_enable;
    logic        seq_wrap;
    logic [30:0] lfsr_state_dbg;
    logic        gen_state_dbg;

    prbs_bit_gen dut (
        .dac_clk         (dac_clk),
        .reset           (reset),
        .enable          (enable),
        .prbs_order_sel  (prbs_order_sel),
        .bit_rate_ftw    (bit_rate_ftw),
        .seed            (seed),
        .seed_load       (seed_load),
        .error_inject    (error_inject),
        .prbs_bit_out    (prbs_bit_out),
        .lfsr_clk_enable (lfsr_clk_enable),
        .seq_wrap        (seq_wrap),
        .lfsr_state_dbg  (lfsr_state_dbg),
        .gen_state_dbg   (gen_state_dbg)
    );

    always #1 dac_clk = ~dac_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the sequence is kept as the last N emitted bits (oldest first);
    // each new bit is the XOR of the bits N and T positions back.
    bit              q[$];
    int              m_n, m_t;
    bit              m_run, m_pend, m_bit, m_stb, m_wrap;
    longint unsigned m_acc;
    logic [30:0]     m_ref;

    function automatic logic [30:0] q_val();
        logic [30:0] r = '0;
        for (int i = 0; i < m_n; i++) r[i] = q[m_n-1-i];
        return r;
    endfunction

    task automatic m_load(input logic [2:0] sel, input logic [30:0] s);
        logic [30:0] v;
        case (sel)
            3'd1:    begin m_n = 9;  m_t = 5;  end
            3'd2:    begin m_n = 15; m_t = 14; end
            3'd3:    begin m_n = 23; m_t = 18; end
            3'd4:    begin m_n = 31; m_t = 28; end
            default: begin m_n = 7;  m_t = 6;  end
        endcase
        v = s & 31'((64'd1 << m_n) - 1);
        if (v == 0) v = 31'((64'd1 << m_n) - 1);
        q.delete();
        for (int i = m_n - 1; i >= 0; i--) q.push_back(v[i]);
        m_ref = v;
    endtask

    always @(posedge dac_clk) begin : model
        bit              tk, inj, fb;
        longint unsigned sum;
        if (reset) begin
            m_run = 0; m_acc = 0; m_pend = 0; m_bit = 0; m_stb = 0; m_wrap = 0;
            m_load(3'd0, 31'h7FFF_FFFF);
        end else begin
            sum   = m_acc + longint'(bit_rate_ftw);
            tk    = m_run && !seed_load && (sum >= 64'h1_0000_0000);
            m_acc = (m_run && !seed_load) ? (sum % 64'h1_0000_0000) : 0;
            inj   = m_pend | error_inject;
            m_stb = 0;
            m_wrap = 0;
            if (seed_load) begin
                m_load(prbs_order_sel, seed);
                m_pend = inj;
            end else if (tk) begin
                fb = q[0] ^ q[m_n - m_t];
                q.push_back(fb);
                void'(q.pop_front());
                m_bit  = fb ^ inj;
                m_stb  = 1;
                m_wrap = (q_val() == m_ref);
                m_pend = 0;
            end else begin
                m_pend = inj;
            end
            m_run = enable;
        end
    end

    bit cmp_on = 0;
    bit mon_on = 0;
    int miss = 0;
    int n_stb = 0;
    bit cap_bits[$];
    int wrap_at[$];

    always @(negedge dac_clk) begin
        if (cmp_on) begin
            chk("bit", prbs_bit_out, m_bit);
            chk("strobe", lfsr_clk_enable, m_stb);
            chk("wrap", seq_wrap, m_wrap);
            chk("state", gen_state_dbg, m_run);
            chk("lfsr", lfsr_state_dbg, q_val());
            if (lfsr_clk_enable) begin
                cap_bits.push_back(prbs_bit_out);
                n_stb++;
                if (seq_wrap) wrap_at.push_back(n_stb);
            end
            if (mon_on) begin
                miss = lfsr_clk_enable ? 0 : miss + 1;
                chk("lfsr_nonzero", lfsr_state_dbg == 0, 0);
                chk("strobe_gap", miss >= 2, 0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge dac_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp7;
        logic       b;
        int         w;
        exp7 = 7'b0000001;

        cyc(2);
        cmp_on = 1;
        cyc(1);
        chk("rst_bit", prbs_bit_out, 0);
        chk("rst_strobe", lfsr_clk_enable, 0);
        chk("rst_wrap", seq_wrap, 0);
        chk("rst_state", gen_state_dbg, 0);
        chk("rst_lfsr", lfsr_state_dbg, 31'h7F);
        reset = 0;

        // PRBS7 from all-ones at half rate
        prbs_order_sel = 3'd0; seed = 31'h7FFF_FFFF; seed_load = 1;
        cyc(1);
        seed_load = 0;
        cap_bits.delete(); wrap_at.delete(); n_stb = 0;
        bit_rate_ftw = 32'h8000_0000; enable = 1;
        cyc(520);
        enable = 0;
        cyc(3);
        for (int i = 0; i < 7; i++) chk("prbs7_first_bits", cap_bits[i], exp7[6-i]);
        chk("prbs7_strobe_count", n_stb, 260);
        chk("prbs7_wrap_count", wrap_at.size(), 2);
        if (wrap_at.size() == 2) begin
            chk("prbs7_wrap_first", wrap_at[0], 127);
            chk("prbs7_wrap_second", wrap_at[1], 254);
        end

        // PRBS31 seed 1, near-full rate, loaded while running
        bit_rate_ftw = 32'hFFFF_FFFF; enable = 1;
        cyc(5);
        prbs_order_sel = 3'd4; seed = 31'd1; seed_load = 1;
        cyc(1);
        seed_load = 0;
        chk("prbs31_seed_dbg", lfsr_state_dbg, 31'd1);
        cap_bits.delete();
        cyc(6);
        mon_on = 1; miss = 0; n_stb = 0;
        for (int i = 0; i < 10200 && n_stb < 10000; i++) cyc(1);
        mon_on = 0;
        chk("prbs31_ticks_reached", n_stb >= 10000, 1);
        chk("prbs31_bit27", cap_bits[26], 0);
        chk("prbs31_bit28", cap_bits[27], 1);

        // PRBS15 zero seed -> lockup protection; later select change ignored
        enable = 0;
        cyc(2);
        prbs_order_sel = 3'd2; seed = 31'd0; seed_load = 1;
        cyc(1);
        seed_load = 0;
        chk("prbs15_zero_seed", lfsr_state_dbg, 31'h7FFF);
        prbs_order_sel = 3'd4; bit_rate_ftw = 32'h8000_0000; enable = 1;
        cyc(200);
        chk("prbs15_order_kept", lfsr_state_dbg[30:15], 0);

        // Error injection between ticks, then coincident with a tick
        w = 0;
        while (!lfsr_clk_enable && w < 10) begin cyc(1); w++; end
        chk("inject_sync", lfsr_clk_enable, 1);
        error_inject = 1;
        cyc(1);
        error_inject = 0;
        cyc(2);
        error_inject = 1;
        cyc(1);
        error_inject = 0;
        cyc(20);

        // Enable dropped for 20 cycles: no strobes, bit held
        enable = 0;
        cyc(2);
        b = prbs_bit_out;
        for (int i = 0; i < 20; i++) begin
            chk("idle_bit_hold", prbs_bit_out, b);
            chk("idle_no_strobe", lfsr_clk_enable, 0);
            cyc(1);
        end
        enable = 1;
        cyc(50);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            error_inject = ($urandom_range(0, 14) == 0);
            seed_load    = ($urandom_range(0, 199) == 0);
            if (seed_load) begin
                prbs_order_sel = 3'($urandom_range(0, 7));
                seed = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bit_rate_ftw = $urandom;
                    1:       bit_rate_ftw = 32'h8000_0000;
                    2:       bit_rate_ftw = 32'hFFFF_FFFF;
                    default: bit_rate_ftw = 32'($urandom_range(1, 32'h3FFF_FFFF));
                endcase
            end
            cyc(1);
        end
        error_inject = 0; seed_load = 0;

        // Reset asserted mid-run
        enable = 1; bit_rate_ftw = 32'h4000_0000;
        cyc(20);
        reset = 1;
        cyc(1);
        chk("midrst_bit", prbs_bit_out, 0);
        chk("midrst_strobe", lfsr_clk_enable, 0);
        chk("midrst_wrap", seq_wrap, 0);
        chk("midrst_state", gen_state_dbg, 0);
        chk("midrst_lfsr", lfsr_state_dbg, 31'h7F);
        reset = 0;

        // Zero tuning word never ticks
        bit_rate_ftw = 32'd0; enable = 1; n_stb = 0;
        cyc(1000);
        chk("ftw0_no_strobe", n_stb, 0);

        enable = 0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
